dmem_port_scheduler: RTL and testbench
======================================

DMEM_PORT_SCHEDULER -- requirements
Module: dmem_port_scheduler

Interface
REQ-001 SHALL have parameter NCORES, default 4: number of requesting cores (≥1).
REQ-002 SHALL have parameter AGE_WIDTH, default 3: width of each per-core starvation counter.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_packed_i, input, NCORES: bit i = core i requests a dmem access (level, held until granted).
REQ-006 SHALL have port addr_packed_i, input, 32*NCORES: core i byte address at bits [32*(i+1)-1:32*i].
REQ-007 SHALL have port done_a_i, input, 1: dmem port A finished its current access.
REQ-008 SHALL have port done_b_i, input, 1: dmem port B finished its current access.
REQ-009 SHALL have port gnt_packed_o, output, NCORES: one-cycle grant pulse per core.
REQ-010 SHALL have port busy_a_o, input-free output, 1: port A holds a grant.
REQ-011 SHALL have port busy_b_o, output, 1: port B holds a grant.
REQ-012 SHALL have port sel_a_o, output, $clog2(NCORES) (min 1): core owning port A.
REQ-013 SHALL have port sel_b_o, output, $clog2(NCORES) (min 1): core owning port B.

Function
REQ-014 SHALL run one FSM per port with states IDLE and BUSY; IDLE->BUSY on grant, BUSY->IDLE on done_x_i; done_x_i in IDLE ignored.
REQ-015 SHALL issue a grant only from IDLE; a port completing in cycle t is grantable again in cycle t+1 (one-cycle bubble).
REQ-016 SHALL treat core i as eligible when req bit i=1 and i is not the owner of a BUSY port.
REQ-017 SHALL pick port A candidate: lowest-index eligible core with saturated age counter; else first eligible core searching upward from rr_ptr with wrap-around at NCORES-1 -> 0.
REQ-018 SHALL pick port B candidate by the same rule after excluding port A candidate and any core whose word address (addr[31:2]) equals that of port A's candidate or port A's current BUSY owner.
REQ-019 SHALL, when port A is BUSY and port B is IDLE, grant port B using the REQ-018 exclusion against port A's owner only.
REQ-020 SHALL register grants: gnt_packed_o bit, busy_x_o and sel_x_o change on the edge following the decision cycle; grant pulse lasts exactly one cycle.
REQ-021 SHALL set rr_ptr to (last granted core + 1) mod NCORES; if both ports grant in a cycle, use port B's core.
REQ-022 SHALL increment core i's age counter each cycle it is eligible and not granted, saturating at 2^AGE_WIDTH-1; clear on grant or when req bit drops.
REQ-023 SHALL never grant the same core on both ports, nor two same-word addresses concurrently.
REQ-024 SHALL with NCORES=1 never grant port B.
REQ-025 SHALL hold sel_x_o at last owner while IDLE (valid only with busy_x_o=1).

Reset
REQ-026 SHALL on rst_i=1 immediately force: both FSMs IDLE, busy_a_o=busy_b_o=0, gnt_packed_o=0, sel_a_o=sel_b_o=0, rr_ptr=0, all age counters 0.
REQ-027 SHALL abandon any in-flight grant on mid-operation reset; done_x_i during reset ignored.
REQ-028 SHALL resume arbitration on the first rising edge after rst_i deasserts.

Structure
REQ-029 SHALL place port FSM state encoding (IDLE, BUSY) and the word-address compare width (30) in the shared dmem package.
REQ-030 SHALL implement candidate selection (REQ-017/018) as one combinational sub-module, rr_candidate_pick, instantiated twice; all state lives in dmem_port_scheduler.

Verification
REQ-031 SHALL cover: reset, req=4'b1111, addresses 0x10/0x20/0x30/0x40 -> next edge gnt=4'b0011, sel_a=0, sel_b=1, rr_ptr=2.
REQ-032 SHALL cover: req=4'b0011, both at 0x100 -> only core 0 granted on A; B stays IDLE until done_a_i, then core 1 granted one cycle after.
REQ-033 SHALL cover: A busy with core 2 (0x80), core 3 requests 0x80 and core 0 requests 0x84 -> B granted core 0, core 3 waits.
REQ-034 SHALL cover: AGE_WIDTH=3, core 3 held off 7 cycles -> core 3 granted on A ahead of rr_ptr order.
REQ-035 SHALL cover: rst_i asserted while both ports BUSY -> busy_a_o=busy_b_o=0 same cycle, gnt=0; first post-reset grant goes to core 0.
REQ-036 SHALL cover: done_a_i and req pending on same cycle -> port A grant appears exactly two edges after done, not one.

Source files
------------

// File: rtl/dmem_port_scheduler_pkg.sv
// dmem_port_scheduler_pkg: shared port FSM encoding and word-address helper
package dmem_port_scheduler_pkg;
    typedef enum logic {IDLE, BUSY} port_state_t;
    localparam int WORD_W = 30;
    function automatic logic [WORD_W-1:0] word_of(input logic [31:0] a);
        return a[31:32-WORD_W];
    endfunction
endpackage

// File: rtl/dmem_port_scheduler_rr_candidate_pick.sv
// rr_candidate_pick: starved-core-first, else round-robin-from-pointer candidate selection
module rr_candidate_pick #(
    parameter int NCORES = 4,
    parameter int SW = 2
) (
    input  logic [NCORES-1:0] i_elig,
    input  logic [NCORES-1:0] i_sat,
    input  logic [SW-1:0]     i_rr_ptr,
    output logic              o_valid,
    output logic [SW-1:0]     o_idx
);
    logic [SW-1:0] w_pos;
    always_comb begin
        o_valid = 1'b0;
        o_idx = '0;
        w_pos = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            w_pos = SW'((int'(i_rr_ptr) + k) % NCORES);
            if (i_elig[w_pos]) begin
                o_valid = 1'b1;
                o_idx = w_pos;
            end
        end
        for (int k = NCORES - 1; k >= 0; k--) begin
            if (i_elig[k] && i_sat[k]) o_idx = SW'(k);
        end
    end
endmodule

// File: rtl/dmem_port_scheduler.sv
// dmem_port_scheduler: two-port dmem arbiter with aging, round-robin and same-word exclusion
module dmem_port_scheduler
    import dmem_port_scheduler_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int AGE_WIDTH = 3,
    localparam int SW = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCORES-1:0]    req_packed_i,
    input  logic [32*NCORES-1:0] addr_packed_i,
    input  logic                 done_a_i,
    input  logic                 done_b_i,
    output logic [NCORES-1:0]    gnt_packed_o,
    output logic                 busy_a_o,
    output logic                 busy_b_o,
    output logic [SW-1:0]        sel_a_o,
    output logic [SW-1:0]        sel_b_o
);
    port_state_t r_st_a, r_st_b, w_st_a_nxt, w_st_b_nxt;
    logic [WORD_W-1:0] r_word_a, r_word_b;
    logic [WORD_W-1:0] w_word [NCORES];
    logic [AGE_WIDTH-1:0] r_age [NCORES];
    logic [SW-1:0] r_rr, w_rr_nxt, w_idx_a, w_idx_b;
    logic [NCORES-1:0] w_elig, w_sat, w_mask_a, w_mask_b, w_gnt;
    logic w_vld_a, w_vld_b, w_go_a, w_go_b;
    assign busy_a_o = r_st_a == BUSY;
    assign busy_b_o = r_st_b == BUSY;
    // Port A also avoids port B's in-flight word so no two same-word accesses overlap.
    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            w_word[i] = word_of(addr_packed_i[32*i +: 32]);
            w_elig[i] = req_packed_i[i] && !(busy_a_o && sel_a_o == SW'(i)) && !(busy_b_o && sel_b_o == SW'(i));
            w_sat[i] = &r_age[i];
            w_mask_a[i] = w_elig[i] && !(busy_b_o && w_word[i] == r_word_b);
        end
    end
    rr_candidate_pick #(.NCORES(NCORES), .SW(SW)) u_pick_a (
        .i_elig(w_mask_a), .i_sat(w_sat), .i_rr_ptr(r_rr), .o_valid(w_vld_a), .o_idx(w_idx_a)
    );
    assign w_go_a = r_st_a == IDLE && w_vld_a;
    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            w_mask_b[i] = w_elig[i] && !(w_go_a && w_word[i] == w_word[w_idx_a]) && !(busy_a_o && w_word[i] == r_word_a);
        end
    end
    rr_candidate_pick #(.NCORES(NCORES), .SW(SW)) u_pick_b (
        .i_elig(w_mask_b), .i_sat(w_sat), .i_rr_ptr(r_rr), .o_valid(w_vld_b), .o_idx(w_idx_b)
    );
    assign w_go_b = NCORES > 1 && r_st_b == IDLE && w_vld_b;
    always_comb begin
        w_gnt = (w_go_a ? NCORES'(1) << w_idx_a : '0) | (w_go_b ? NCORES'(1) << w_idx_b : '0);
        w_st_a_nxt = w_go_a ? BUSY : (busy_a_o && !done_a_i) ? BUSY : IDLE;
        w_st_b_nxt = w_go_b ? BUSY : (busy_b_o && !done_b_i) ? BUSY : IDLE;
        w_rr_nxt = w_go_b ? ((w_idx_b == SW'(NCORES - 1)) ? '0 : w_idx_b + 1'b1)
                 : w_go_a ? ((w_idx_a == SW'(NCORES - 1)) ? '0 : w_idx_a + 1'b1) : r_rr;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st_a <= IDLE;
            r_st_b <= IDLE;
        end else begin
            r_st_a <= w_st_a_nxt;
            r_st_b <= w_st_b_nxt;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_packed_o <= '0;
            sel_a_o <= '0;
            sel_b_o <= '0;
            r_word_a <= '0;
            r_word_b <= '0;
            r_rr <= '0;
            for (int i = 0; i < NCORES; i++) r_age[i] <= '0;
        end else begin
            gnt_packed_o <= w_gnt;
            r_rr <= w_rr_nxt;
            if (w_go_a) begin
                sel_a_o <= w_idx_a;
                r_word_a <= w_word[w_idx_a];
            end
            if (w_go_b) begin
                sel_b_o <= w_idx_b;
                r_word_b <= w_word[w_idx_b];
            end
            for (int i = 0; i < NCORES; i++) begin
                r_age[i] <= (!req_packed_i[i] || w_gnt[i]) ? '0
                          : (w_elig[i] && !w_sat[i]) ? r_age[i] + 1'b1 : r_age[i];
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_scheduler.sv
// tb_dmem_port_scheduler: directed scenario tasks with hand-computed expectations
module tb_dmem_port_scheduler;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [3:0]   req_packed_i = '0;
    logic [127:0] addr_packed_i = '0;
    logic         done_a_i = 1'b0;
    logic         done_b_i = 1'b0;
    logic [3:0]   gnt_packed_o;
    logic         busy_a_o, busy_b_o;
    logic [1:0]   sel_a_o, sel_b_o;
    int errors = 0;
    int checks = 0;

    dmem_port_scheduler #(.NCORES(4), .AGE_WIDTH(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_packed_i(req_packed_i), .addr_packed_i(addr_packed_i),
        .done_a_i(done_a_i), .done_b_i(done_b_i), .gnt_packed_o(gnt_packed_o),
        .busy_a_o(busy_a_o), .busy_b_o(busy_b_o), .sel_a_o(sel_a_o), .sel_b_o(sel_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_packed_i = '0;
        done_a_i = 1'b0;
        done_b_i = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (gnt_packed_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt_packed_o); end
        checks++; if ({busy_a_o, busy_b_o} !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b exp=00", {busy_a_o, busy_b_o}); end
        checks++; if ({sel_a_o, sel_b_o} !== 4'b0000) begin errors++; $display("FAIL reset_sel got=%b exp=0000", {sel_a_o, sel_b_o}); end
    endtask

    task automatic test_basic();
        do_reset();
        addr_packed_i = {32'h40, 32'h30, 32'h20, 32'h10};
        req_packed_i = 4'b1111;
        tick();
        checks++; if (gnt_packed_o !== 4'b0011) begin errors++; $display("FAIL basic_gnt got=%b exp=0011", gnt_packed_o); end
        checks++; if (sel_a_o !== 2'd0 || sel_b_o !== 2'd1) begin errors++; $display("FAIL basic_sel got=%0d/%0d exp=0/1", sel_a_o, sel_b_o); end
        checks++; if ({busy_a_o, busy_b_o} !== 2'b11) begin errors++; $display("FAIL basic_busy got=%b exp=11", {busy_a_o, busy_b_o}); end
        req_packed_i = 4'b1100;
        tick();
        checks++; if (gnt_packed_o !== 4'b0000) begin errors++; $display("FAIL basic_pulse got=%b exp=0000", gnt_packed_o); end
        done_a_i = 1'b1;
        done_b_i = 1'b1;
        tick();
        done_a_i = 1'b0;
        done_b_i = 1'b0;
        checks++; if (gnt_packed_o !== 4'b0000 || {busy_a_o, busy_b_o} !== 2'b00) begin errors++; $display("FAIL basic_bubble got=%b/%b exp=0000/00", gnt_packed_o, {busy_a_o, busy_b_o}); end
        tick();
        checks++; if (gnt_packed_o !== 4'b1100) begin errors++; $display("FAIL basic_rr_gnt got=%b exp=1100", gnt_packed_o); end
        checks++; if (sel_a_o !== 2'd2 || sel_b_o !== 2'd3) begin errors++; $display("FAIL basic_rr_sel got=%0d/%0d exp=2/3", sel_a_o, sel_b_o); end
    endtask

    task automatic test_same_word();
        do_reset();
        addr_packed_i = {32'h0, 32'h0, 32'h102, 32'h100};
        req_packed_i = 4'b0011;
        tick();
        checks++; if (gnt_packed_o !== 4'b0001) begin errors++; $display("FAIL sw_gnt got=%b exp=0001", gnt_packed_o); end
        checks++; if ({busy_a_o, busy_b_o} !== 2'b10) begin errors++; $display("FAIL sw_busy got=%b exp=10", {busy_a_o, busy_b_o}); end
        req_packed_i = 4'b0010;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++; if (busy_b_o !== 1'b0 || gnt_packed_o !== 4'b0000) begin errors++; $display("FAIL sw_hold got=%b/%b exp=0/0000", busy_b_o, gnt_packed_o); end
        end
        done_a_i = 1'b1;
        tick();
        done_a_i = 1'b0;
        checks++; if (busy_a_o !== 1'b0 || gnt_packed_o !== 4'b0000) begin errors++; $display("FAIL sw_done got=%b/%b exp=0/0000", busy_a_o, gnt_packed_o); end
        tick();
        checks++; if (gnt_packed_o !== 4'b0010 || sel_a_o !== 2'd1) begin errors++; $display("FAIL sw_regrant got=%b/%0d exp=0010/1", gnt_packed_o, sel_a_o); end
        checks++; if (busy_b_o !== 1'b0) begin errors++; $display("FAIL sw_b_idle got=%b exp=0", busy_b_o); end
    endtask

    task automatic test_addr_conflict();
        do_reset();
        addr_packed_i = {32'h80, 32'h80, 32'h0, 32'h84};
        req_packed_i = 4'b0100;
        tick();
        checks++; if (gnt_packed_o !== 4'b0100 || sel_a_o !== 2'd2) begin errors++; $display("FAIL ac_a got=%b/%0d exp=0100/2", gnt_packed_o, sel_a_o); end
        req_packed_i = 4'b1001;
        tick();
        checks++; if (gnt_packed_o !== 4'b0001 || sel_b_o !== 2'd0 || busy_b_o !== 1'b1) begin errors++; $display("FAIL ac_b got=%b/%0d/%b exp=0001/0/1", gnt_packed_o, sel_b_o, busy_b_o); end
        req_packed_i = 4'b1000;
        tick();
        checks++; if (gnt_packed_o !== 4'b0000) begin errors++; $display("FAIL ac_wait got=%b exp=0000", gnt_packed_o); end
    endtask

    task automatic test_aging();
        do_reset();
        addr_packed_i = {32'h40, 32'h30, 32'h20, 32'h10};
        req_packed_i = 4'b0011;
        tick();
        checks++; if (gnt_packed_o !== 4'b0011) begin errors++; $display("FAIL age_setup got=%b exp=0011", gnt_packed_o); end
        req_packed_i = 4'b1000;
        repeat (7) tick();
        req_packed_i = 4'b1100;
        done_a_i = 1'b1;
        done_b_i = 1'b1;
        tick();
        done_a_i = 1'b0;
        done_b_i = 1'b0;
        tick();
        checks++; if (gnt_packed_o !== 4'b1100) begin errors++; $display("FAIL age_gnt got=%b exp=1100", gnt_packed_o); end
        checks++; if (sel_a_o !== 2'd3 || sel_b_o !== 2'd2) begin errors++; $display("FAIL age_sel got=%0d/%0d exp=3/2", sel_a_o, sel_b_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        addr_packed_i = {32'h40, 32'h30, 32'h20, 32'h10};
        req_packed_i = 4'b0011;
        tick();
        checks++; if ({busy_a_o, busy_b_o} !== 2'b11) begin errors++; $display("FAIL mr_setup got=%b exp=11", {busy_a_o, busy_b_o}); end
        req_packed_i = 4'b1001;
        rst_i = 1'b1;
        done_a_i = 1'b1;
        #1;
        checks++; if ({busy_a_o, busy_b_o} !== 2'b00 || gnt_packed_o !== 4'b0000) begin errors++; $display("FAIL mr_async got=%b/%b exp=00/0000", {busy_a_o, busy_b_o}, gnt_packed_o); end
        tick();
        rst_i = 1'b0;
        done_a_i = 1'b0;
        tick();
        checks++; if (gnt_packed_o !== 4'b1001 || sel_a_o !== 2'd0 || sel_b_o !== 2'd3) begin errors++; $display("FAIL mr_resume got=%b/%0d/%0d exp=1001/0/3", gnt_packed_o, sel_a_o, sel_b_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        addr_packed_i = {32'h0, 32'h202, 32'h0, 32'h200};
        req_packed_i = 4'b0001;
        tick();
        checks++; if (gnt_packed_o !== 4'b0001) begin errors++; $display("FAIL b2b_setup got=%b exp=0001", gnt_packed_o); end
        req_packed_i = 4'b0100;
        tick();
        checks++; if (busy_b_o !== 1'b0) begin errors++; $display("FAIL b2b_b_excl got=%b exp=0", busy_b_o); end
        done_a_i = 1'b1;
        tick();
        done_a_i = 1'b0;
        checks++; if (gnt_packed_o !== 4'b0000 || busy_a_o !== 1'b0) begin errors++; $display("FAIL b2b_edge1 got=%b/%b exp=0000/0", gnt_packed_o, busy_a_o); end
        tick();
        checks++; if (gnt_packed_o !== 4'b0100 || sel_a_o !== 2'd2 || busy_a_o !== 1'b1) begin errors++; $display("FAIL b2b_edge2 got=%b/%0d/%b exp=0100/2/1", gnt_packed_o, sel_a_o, busy_a_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_word();
        test_addr_conflict();
        test_aging();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
